// File: rtl/dds_wave_gen.sv
// Key-controlled DDS source: a phase accumulator drives a sine/triangle/sawtooth/square
// mapper whose registered 8-bit sample feeds the waveform display stage.
module dds_wave_gen #(
  parameter int unsigned PHASE_W    = 32,
  parameter logic [31:0] FWORD_INIT = 32'h0147_AE14,
  parameter logic [31:0] FWORD_STEP = 32'h0147_AE14,
  parameter logic [31:0] FWORD_MAX  = 32'h0CCC_CCC8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         key_out,
  output logic [7:0]         wave,
  output logic [1:0]         wave_sel,
  output logic [PHASE_W-1:0] fword,
  output logic               phase_wrap
);

  localparam logic [PHASE_W-1:0] INIT_W = FWORD_INIT[PHASE_W-1:0];
  localparam logic [PHASE_W-1:0] STEP_W = FWORD_STEP[PHASE_W-1:0];
  localparam logic [PHASE_W-1:0] MAX_W  = FWORD_MAX[PHASE_W-1:0];

  // Quarter-wave sine table: round(127*sin(2*pi*(q+0.5)/256)).
  function automatic logic [6:0] sine_lut(input logic [5:0] q);
    case (q)
      6'd0:  sine_lut = 7'd2;
      6'd1:  sine_lut = 7'd5;
      6'd2:  sine_lut = 7'd8;
      6'd3:  sine_lut = 7'd11;
      6'd4:  sine_lut = 7'd14;
      6'd5:  sine_lut = 7'd17;
      6'd6:  sine_lut = 7'd20;
      6'd7:  sine_lut = 7'd23;
      6'd8:  sine_lut = 7'd26;
      6'd9:  sine_lut = 7'd29;
      6'd10: sine_lut = 7'd32;
      6'd11: sine_lut = 7'd35;
      6'd12: sine_lut = 7'd38;
      6'd13: sine_lut = 7'd41;
      6'd14: sine_lut = 7'd44;
      6'd15: sine_lut = 7'd47;
      6'd16: sine_lut = 7'd50;
      6'd17: sine_lut = 7'd53;
      6'd18: sine_lut = 7'd56;
      6'd19: sine_lut = 7'd58;
      6'd20: sine_lut = 7'd61;
      6'd21: sine_lut = 7'd64;
      6'd22: sine_lut = 7'd67;
      6'd23: sine_lut = 7'd69;
      6'd24: sine_lut = 7'd72;
      6'd25: sine_lut = 7'd74;
      6'd26: sine_lut = 7'd77;
      6'd27: sine_lut = 7'd79;
      6'd28: sine_lut = 7'd82;
      6'd29: sine_lut = 7'd84;
      6'd30: sine_lut = 7'd86;
      6'd31: sine_lut = 7'd89;
      6'd32: sine_lut = 7'd91;
      6'd33: sine_lut = 7'd93;
      6'd34: sine_lut = 7'd95;
      6'd35: sine_lut = 7'd97;
      6'd36: sine_lut = 7'd99;
      6'd37: sine_lut = 7'd101;
      6'd38: sine_lut = 7'd103;
      6'd39: sine_lut = 7'd105;
      6'd40: sine_lut = 7'd106;
      6'd41: sine_lut = 7'd108;
      6'd42: sine_lut = 7'd110;
      6'd43: sine_lut = 7'd111;
      6'd44: sine_lut = 7'd113;
      6'd45: sine_lut = 7'd114;
      6'd46: sine_lut = 7'd115;
      6'd47: sine_lut = 7'd117;
      6'd48: sine_lut = 7'd118;
      6'd49: sine_lut = 7'd119;
      6'd50: sine_lut = 7'd120;
      6'd51: sine_lut = 7'd121;
      6'd52: sine_lut = 7'd122;
      6'd53: sine_lut = 7'd123;
      6'd54: sine_lut = 7'd124;
      6'd55: sine_lut = 7'd124;
      6'd56: sine_lut = 7'd125;
      6'd57: sine_lut = 7'd125;
      6'd58: sine_lut = 7'd126;
      6'd59: sine_lut = 7'd126;
      6'd60: sine_lut = 7'd127;
      6'd61: sine_lut = 7'd127;
      6'd62: sine_lut = 7'd127;
      6'd63: sine_lut = 7'd127;
      default: sine_lut = 7'd127;
    endcase
  endfunction

  // Map the top 8 phase bits to a sample; sine mirrors the quarter table per quadrant.
  function automatic logic [7:0] shape_sample(input logic [1:0] sel, input logic [7:0] p);
    logic [5:0] q;
    logic [6:0] l;
    q = p[6] ? (6'd63 - p[5:0]) : p[5:0];
    l = sine_lut(q);
    case (sel)
      2'd0:    shape_sample = p[7] ? (8'd127 - {1'b0, l}) : (8'd128 + {1'b0, l});
      2'd1:    shape_sample = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
      2'd2:    shape_sample = p;
      2'd3:    shape_sample = p[7] ? 8'd0 : 8'd255;
      default: shape_sample = 8'd0;
    endcase
  endfunction

  logic [PHASE_W-1:0] phase_r;
  logic [PHASE_W-1:0] fword_r;
  logic [1:0]         sel_r;
  logic               carry_r;
  logic [7:0]         wave_r;
  logic               phase_wrap_r;

  logic               key_any_s;
  logic [PHASE_W:0]   sum_s;
  logic [PHASE_W:0]   fstep_sum_s;
  logic [PHASE_W-1:0] fword_next_s;
  logic [7:0]         sample_s;

  assign key_any_s   = |key_out;
  assign sum_s       = {1'b0, phase_r} + {1'b0, fword_r};
  assign fstep_sum_s = {1'b0, fword_r} + {1'b0, STEP_W};
  assign sample_s    = shape_sample(sel_r, phase_r[PHASE_W-1 -: 8]);

  // Next frequency word: wide sum so a step past the top never aliases below MAX.
  always_comb begin
    fword_next_s = fword_r;
    if (fstep_sum_s > {1'b0, MAX_W}) begin
      fword_next_s = INIT_W;
    end else begin
      fword_next_s = fstep_sum_s[PHASE_W-1:0];
    end
  end

  // Frequency word and waveshape registers, stepped by key pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fword_r <= INIT_W;
      sel_r   <= 2'd0;
    end else begin
      if (key_out[0]) fword_r <= fword_next_s;
      if (key_out[1]) sel_r   <= sel_r + 2'd1;
    end
  end

  // Phase accumulator; a key pulse restarts the frame at phase 0 and drops the carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= {PHASE_W{1'b0}};
      carry_r <= 1'b0;
    end else if (key_any_s) begin
      phase_r <= {PHASE_W{1'b0}};
      carry_r <= 1'b0;
    end else begin
      phase_r <= sum_s[PHASE_W-1:0];
      carry_r <= sum_s[PHASE_W];
    end
  end

  // Output register: sample and wrap flag one clock behind the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_r       <= 8'd0;
      phase_wrap_r <= 1'b0;
    end else begin
      wave_r       <= sample_s;
      phase_wrap_r <= carry_r;
    end
  end

  assign wave       = wave_r;
  assign wave_sel   = sel_r;
  assign fword      = fword_r;
  assign phase_wrap = phase_wrap_r;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Bench for dds_wave_gen: two instances (default and slow fword) checked every cycle
// against an arithmetic model, plus directed literal expectations.
module tb_dds_wave_gen;

  localparam logic [31:0] INIT0 = 32'h0147_AE14;
  localparam logic [31:0] INIT1 = 32'h0100_0000;
  localparam logic [31:0] STEP  = 32'h0147_AE14;
  localparam logic [31:0] MAXW  = 32'h0CCC_CCC8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  key   [2];
  logic [7:0]  wave  [2];
  logic [1:0]  sel   [2];
  logic [31:0] fword [2];
  logic        wrap  [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dds_wave_gen u0 (
    .clk(clk), .rst_n(rst_n), .key_out(key[0]),
    .wave(wave[0]), .wave_sel(sel[0]), .fword(fword[0]), .phase_wrap(wrap[0])
  );

  dds_wave_gen #(.FWORD_INIT(INIT1)) u1 (
    .clk(clk), .rst_n(rst_n), .key_out(key[1]),
    .wave(wave[1]), .wave_sel(sel[1]), .fword(fword[1]), .phase_wrap(wrap[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference shapes from plain arithmetic; sine straight from $sin.
  function automatic int sine_ref(input int p);
    real a;
    int  r;
    a = 127.0 * $sin(2.0 * 3.14159265358979 * (p + 0.5) / 256.0);
    if (a < 0.0) a = -a;
    r = $rtoi(a + 0.5);
    return (p < 128) ? 128 + r : 127 - r;
  endfunction

  function automatic int shape_ref(input int s, input int p);
    case (s)
      0:       return sine_ref(p);
      1:       return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
      2:       return p;
      default: return (p < 128) ? 255 : 0;
    endcase
  endfunction

  function automatic logic [31:0] init_of(input int i);
    return (i == 0) ? INIT0 : INIT1;
  endfunction

  logic [31:0] m_phase [2];
  logic [31:0] m_fword [2];
  logic [1:0]  m_sel   [2];
  logic        m_ovf   [2];
  logic [7:0]  m_wave  [2];
  logic        m_wrap  [2];

  // Behavioural model of both instances.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_phase[i] <= 32'd0;
        m_fword[i] <= init_of(i);
        m_sel[i]   <= 2'd0;
        m_ovf[i]   <= 1'b0;
        m_wave[i]  <= 8'd0;
        m_wrap[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_wave[i] <= 8'(shape_ref(int'(m_sel[i]), int'(m_phase[i][31:24])));
        m_wrap[i] <= m_ovf[i];
        if (key[i] != 2'b00) begin
          m_phase[i] <= 32'd0;
          m_ovf[i]   <= 1'b0;
        end else begin
          m_phase[i] <= m_phase[i] + m_fword[i];
          m_ovf[i]   <= (64'(m_phase[i]) + 64'(m_fword[i])) >= 64'h1_0000_0000;
        end
        if (key[i][0])
          m_fword[i] <= ((64'(m_fword[i]) + 64'(STEP)) > 64'(MAXW)) ? init_of(i) : m_fword[i] + STEP;
        if (key[i][1])
          m_sel[i] <= m_sel[i] + 2'd1;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d wave", i), 64'(wave[i]), 64'(m_wave[i]));
      check($sformatf("u%0d phase_wrap", i), 64'(wrap[i]), 64'(m_wrap[i]));
      check($sformatf("u%0d fword", i), 64'(fword[i]), 64'(m_fword[i]));
      check($sformatf("u%0d wave_sel", i), 64'(sel[i]), 64'(m_sel[i]));
    end
  end

  logic [7:0] rec  [257];
  logic       recw [257];

  task automatic pulse(input int i, input logic [1:0] k);
    key[i] = k;
    @(negedge clk);
    key[i] = 2'b00;
  endtask

  task automatic sweep();
    for (int j = 0; j < 257; j++) begin
      @(negedge clk);
      rec[j]  = wave[1];
      recw[j] = wrap[1];
    end
  endtask

  task automatic check_wraps(input string name);
    int wc;
    wc = 0;
    for (int j = 0; j < 257; j++) if (recw[j]) wc++;
    check({name, " wrap count"}, 64'(wc), 64'd1);
    check({name, " wrap at 256"}, 64'(recw[256]), 64'd1);
    check({name, " sample at wrap"}, 64'(rec[256]), 64'(rec[0]));
  endtask

  initial begin
    int bad;
    int wc;
    key[0] = 2'b00;
    key[1] = 2'b00;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset wave", 64'(wave[0]), 64'd0);
    check("reset fword", 64'(fword[0]), 64'h0147_AE14);
    check("reset wave_sel", 64'(sel[0]), 64'd0);
    check("reset phase_wrap", 64'(wrap[0]), 64'd0);
    @(negedge clk);
    check("first sample u0", 64'(wave[0]), 64'd130);
    check("first sample u1", 64'(wave[1]), 64'd130);
    check("first wrap", 64'(wrap[0]), 64'd0);

    // Triangle on the slow instance.
    pulse(1, 2'b10);
    sweep();
    check_wraps("tri");
    check("tri p0", 64'(rec[0]), 64'd0);
    check("tri p1", 64'(rec[1]), 64'd2);
    check("tri p127", 64'(rec[127]), 64'd254);
    check("tri p128", 64'(rec[128]), 64'd255);
    check("tri p129", 64'(rec[129]), 64'd253);
    check("tri p255", 64'(rec[255]), 64'd1);

    // Sawtooth.
    pulse(1, 2'b10);
    sweep();
    check_wraps("saw");
    bad = 0;
    for (int j = 0; j < 256; j++) if (int'(rec[j]) != j) bad++;
    check("saw ramp errors", 64'(bad), 64'd0);
    check("saw p255", 64'(rec[255]), 64'd255);
    check("saw after wrap", 64'(rec[256]), 64'd0);

    // Square.
    pulse(1, 2'b10);
    sweep();
    check_wraps("sq");
    bad = 0;
    for (int j = 0; j < 256; j++) if (rec[j] == 8'd255) bad++;
    check("sq high count", 64'(bad), 64'd128);
    check("sq p127", 64'(rec[127]), 64'd255);
    check("sq p128", 64'(rec[128]), 64'd0);

    // Sine, back from square.
    pulse(1, 2'b10);
    sweep();
    check_wraps("sine");
    check("sine p0", 64'(rec[0]), 64'd130);
    check("sine p63", 64'(rec[63]), 64'd255);
    check("sine p64", 64'(rec[64]), 64'd255);
    check("sine p127", 64'(rec[127]), 64'd130);
    check("sine p128", 64'(rec[128]), 64'd125);
    check("sine p191", 64'(rec[191]), 64'd0);
    check("sine p192", 64'(rec[192]), 64'd0);
    check("sine p32", 64'(rec[32]), 64'd219);
    bad = 0;
    for (int j = 0; j < 128; j++) if (int'(rec[j]) + int'(rec[j + 128]) != 255) bad++;
    check("sine half-wave symmetry", 64'(bad), 64'd0);

    // Ten frequency steps on the default instance: 2x..10x then wrap to INIT.
    for (int k = 1; k <= 10; k++) begin
      pulse(0, 2'b01);
      check($sformatf("fword after step %0d", k), 64'(fword[0]),
            (k < 10) ? 64'(INIT0) * 64'(k + 1) : 64'h0147_AE14);
      @(negedge clk);
      check($sformatf("wave after step %0d", k), 64'(wave[0]), 64'd130);
      check($sformatf("wrap after step %0d", k), 64'(wrap[0]), 64'd0);
    end

    // Climb back to MAX, select square, then hit both keys at once.
    for (int k = 1; k <= 9; k++) pulse(0, 2'b01);
    check("fword at max", 64'(fword[0]), 64'h0CCC_CCC8);
    for (int k = 0; k < 3; k++) pulse(0, 2'b10);
    repeat (37) @(negedge clk);
    check("sel before both", 64'(sel[0]), 64'd3);
    pulse(0, 2'b11);
    check("both keys sel", 64'(sel[0]), 64'd0);
    check("both keys fword", 64'(fword[0]), 64'h0147_AE14);
    @(negedge clk);
    check("both keys wave", 64'(wave[0]), 64'd130);
    check("both keys wrap", 64'(wrap[0]), 64'd0);

    // Two accumulator overflows in 450 samples at the default word.
    wc = 0;
    for (int j = 0; j < 450; j++) begin
      @(negedge clk);
      if (wrap[0]) wc++;
    end
    check("default wrap count", 64'(wc), 64'd2);

    // Asynchronous reset mid-period with a non-default word and shape.
    pulse(0, 2'b01);
    pulse(0, 2'b10);
    repeat (23) @(negedge clk);
    check("pre-reset fword", 64'(fword[0]), 64'h028F_5C28);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset wave", 64'(wave[0]), 64'd0);
    check("async reset fword", 64'(fword[0]), 64'h0147_AE14);
    check("async reset sel", 64'(sel[0]), 64'd0);
    check("async reset wrap", 64'(wrap[0]), 64'd0);
    check("async reset u1 fword", 64'(fword[1]), 64'h0100_0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset sample", 64'(wave[0]), 64'd130);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
